// File: rtl/adder_accum_ctrl.sv
// Operand/result register stage around an external carry-select adder chain.
// Holds A (accumulator) and B, waits a settle time, then captures Sum/Cout into A.
module adder_accum_ctrl #(
  parameter int unsigned WIDTH         = 16,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadB,
  input  logic             Run,
  input  logic             ClearA,
  input  logic [WIDTH-1:0] SW,
  input  logic [WIDTH-1:0] Sum_in,
  input  logic             Cout_in,
  output logic [WIDTH-1:0] A_out,
  output logic [WIDTH-1:0] B_out,
  output logic [WIDTH-1:0] Sum,
  output logic             CO,
  output logic             Busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    HOLD
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t           state, state_d;
  logic [3:0]       cnt, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;

  logic run_q, loadb_q, hist_valid;
  logic run_rise, loadb_rise;

  // hist_valid masks the first post-reset cycle so a button held through
  // reset is seen as already high rather than as a fresh rising edge.
  assign run_rise   = Run   & ~run_q   & hist_valid;
  assign loadb_rise = LoadB & ~loadb_q & hist_valid;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      sum_q      <= '0;
      co_q       <= 1'b0;
      run_q      <= 1'b0;
      loadb_q    <= 1'b0;
      hist_valid <= 1'b0;
    end else begin
      cnt        <= cnt_d;
      a_q        <= a_d;
      b_q        <= b_d;
      sum_q      <= sum_d;
      co_q       <= co_d;
      run_q      <= Run;
      loadb_q    <= LoadB;
      hist_valid <= 1'b1;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    co_d    = co_q;
    unique case (state)
      IDLE: begin
        if (run_rise) begin
          state_d = SETTLE;
          cnt_d   = CNT_INIT;
        end else if (loadb_rise) begin
          b_d = SW;
        end else if (ClearA) begin
          a_d = '0;
        end
      end
      SETTLE: begin
        if (cnt == 4'd0) begin
          state_d = CAPTURE;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      CAPTURE: begin
        sum_d   = Sum_in;
        co_d    = Cout_in;
        a_d     = Sum_in;
        state_d = HOLD;
      end
      HOLD: begin
        if (!Run) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign Busy  = (state == SETTLE) || (state == CAPTURE);
  assign A_out = a_q;
  assign B_out = b_q;
  assign Sum   = sum_q;
  assign CO    = co_q;

endmodule

// File: tb/tb_adder_accum_ctrl.sv
// Self-checking bench for adder_accum_ctrl: directed scenarios plus random
// LoadB/Run/ClearA operations checked against an arithmetic accumulator model.
module tb_adder_accum_ctrl;

  localparam int unsigned W = 16;
  localparam int unsigned S = 2;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         LoadB = 1'b0;
  logic         Run = 1'b0;
  logic         ClearA = 1'b0;
  logic [W-1:0] SW = '0;
  logic [W-1:0] Sum_in;
  logic         Cout_in;
  logic [W-1:0] A_out, B_out, Sum;
  logic         CO, Busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] mA = '0, mB = '0, mSum = '0;
  logic         mCO = 1'b0;

  adder_accum_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .Clk(Clk), .Reset(Reset), .LoadB(LoadB), .Run(Run), .ClearA(ClearA),
    .SW(SW), .Sum_in(Sum_in), .Cout_in(Cout_in),
    .A_out(A_out), .B_out(B_out), .Sum(Sum), .CO(CO), .Busy(Busy)
  );

  // Stand-in for the external adder chain
  assign {Cout_in, Sum_in} = {1'b0, A_out} + {1'b0, B_out};

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_zero();
    mA = '0; mB = '0; mSum = '0; mCO = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_a"},   32'(A_out), 32'(mA));
    check({tag, "_b"},   32'(B_out), 32'(mB));
    check({tag, "_sum"}, 32'(Sum),   32'(mSum));
    check({tag, "_co"},  32'(CO),    32'(mCO));
  endtask

  task automatic do_reset();
    Run = 1'b0; LoadB = 1'b0; ClearA = 1'b0;
    #2 Reset = 1'b1;
    #2 Reset = 1'b0;
    model_zero();
    tick();
    tick();
  endtask

  task automatic load_b(input logic [W-1:0] sw);
    SW = sw; LoadB = 1'b1;
    tick();
    LoadB = 1'b0;
    tick();
    mB = sw;
    check_all("loadb");
  endtask

  task automatic clear_a();
    ClearA = 1'b1;
    tick();
    ClearA = 1'b0;
    mA = '0;
    check_all("clra");
  endtask

  // One Run press. Optionally raises LoadB in the same cycle as Run, jitters
  // LoadB/ClearA/SW while busy, and holds Run (with ClearA high) hold_extra cycles.
  task automatic run_add(input bit with_load, input logic [W-1:0] sw, input int unsigned hold_extra);
    logic [W-1:0] a0, b0, s0;
    logic [W:0]   r;
    int unsigned  n;
    a0 = mA; b0 = mB; s0 = mSum;
    if (with_load) begin
      SW = sw; LoadB = 1'b1;
    end
    Run = 1'b1;
    tick();
    LoadB = 1'b0;
    n = 0;
    while (Busy === 1'b1 && n < 40) begin
      check("frz_a",   32'(A_out), 32'(a0));
      check("frz_b",   32'(B_out), 32'(b0));
      check("frz_sum", 32'(Sum),   32'(s0));
      n++;
      LoadB  = 1'($urandom_range(0, 1));
      ClearA = 1'($urandom_range(0, 1));
      SW     = W'($urandom);
      tick();
    end
    LoadB = 1'b0; ClearA = 1'b0;
    check("busy_len", n, S + 1);
    r = {1'b0, a0} + {1'b0, b0};
    mSum = r[W-1:0]; mCO = r[W]; mA = r[W-1:0];
    check_all("add");
    for (int unsigned i = 0; i < hold_extra; i++) begin
      ClearA = 1'b1;
      tick();
      check("hold_busy", 32'(Busy), 32'd0);
      check_all("hold");
    end
    ClearA = 1'b0; Run = 1'b0;
    tick();
    tick();
    check_all("rel");
  endtask

  initial begin
    // Reset state
    #3;
    check("rst_busy", 32'(Busy), 32'd0);
    check_all("rst");
    Reset = 1'b0;
    tick();
    tick();
    check_all("post_rst");

    // 1 and 2: running sum of 3
    load_b(16'h0003);
    run_add(1'b0, '0, 0);
    check("t1_sum", 32'(Sum), 32'h0003);
    run_add(1'b0, '0, 0);
    check("t2_sum", 32'(Sum), 32'h0006);
    run_add(1'b0, '0, 20);
    check("t2_sum2", 32'(Sum), 32'h0009);

    // 3: overflow to zero, carry not fed back
    do_reset();
    load_b(16'h5555);
    for (int i = 0; i < 3; i++) run_add(1'b0, '0, 0);
    check("t3_a", 32'(A_out), 32'hFFFF);
    load_b(16'h0001);
    run_add(1'b0, '0, 0);
    check("t3_sum", 32'(Sum), 32'h0000);
    check("t3_co", 32'(CO), 32'd1);
    run_add(1'b0, '0, 0);
    check("t3_nofb", 32'(Sum), 32'h0001);
    check("t3_co2", 32'(CO), 32'd0);

    // 4: LoadB coincident with Run is lost
    run_add(1'b1, 16'h00AA, 0);
    check("t4_b", 32'(B_out), 32'h0001);

    // 5: reset mid-settle, Run held across release
    load_b(16'h0010);
    Run = 1'b1;
    tick();
    check("t5_busy", 32'(Busy), 32'd1);
    #2 Reset = 1'b1;
    #1;
    model_zero();
    check("t5_rbusy", 32'(Busy), 32'd0);
    check_all("t5_async");
    #3 Reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_noadd", 32'(Busy), 32'd0);
      check_all("t5_held");
    end
    Run = 1'b0;
    tick();
    tick();
    load_b(16'h0007);
    run_add(1'b0, '0, 0);
    check("t5_sum", 32'(Sum), 32'h0007);

    // 6: ClearA in IDLE clears A only
    clear_a();
    check("t6_sum", 32'(Sum), 32'h0007);
    run_add(1'b0, '0, 3);

    // Random operation mix
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: load_b(W'($urandom));
        1: clear_a();
        2: run_add(1'($urandom_range(0, 1)), W'($urandom), $urandom_range(0, 3));
        default: run_add(1'b0, '0, 0);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
